// File: rtl/gemini_exc_pkg.sv
// Shared definitions for the execute-stage multiply/divide unit:
// operation encodings, FSM state encoding and the divide-by-zero LO value.
package gemini_exc_pkg;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_MUL  = 3'd1,
    ST_DIV  = 3'd2,
    ST_FIX  = 3'd3,
    ST_DONE = 3'd4
  } state_e;

  localparam logic [31:0] DIV_ZERO_LO = 32'hFFFF_FFFF;

  // True for the two-complement (signed) flavours of multiply and divide.
  function automatic logic is_signed_op(input logic [1:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/exc_div_step.sv
// One combinational restoring-divide step: shift the next dividend bit into
// the partial remainder, subtract the divisor when it fits, and shift the
// resulting quotient bit into the low end of the dividend/quotient register.
module exc_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_rem,
  input  logic [WIDTH-1:0] i_quo,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [WIDTH-1:0] o_rem,
  output logic [WIDTH-1:0] o_quo
);

  logic [WIDTH:0] w_trial;
  logic           w_ge;

  // Trial remainder is one bit wider so the compare never overflows.
  assign w_trial = {i_rem, i_quo[WIDTH-1]};
  assign w_ge    = (w_trial >= {1'b0, i_divisor});
  assign o_rem   = w_ge ? (w_trial[WIDTH-1:0] - i_divisor) : w_trial[WIDTH-1:0];
  assign o_quo   = {i_quo[WIDTH-2:0], w_ge};

endmodule

// File: rtl/exc_muldiv.sv
// Execute-stage multi-cycle multiply/divide unit producing HI/LO results.
// MULT/MULTU finish in two cycles; DIV/DIVU run a radix-2 restoring loop on
// operand magnitudes followed by a sign-correction cycle.
// Optional build macro: EXC_MULDIV_EARLY_OUT_EN - skip the divide loop when
// the quotient is trivially zero (results are identical, only latency drops).
module exc_muldiv
  import gemini_exc_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int DIV_ITERS = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             exception_flush,
  input  logic             stall_i,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] src_a_i,
  input  logic [WIDTH-1:0] src_b_i,
  output logic             stall_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int CNT_W = $clog2(DIV_ITERS + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_ITERS - 1);

  state_e             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_rem;
  logic [WIDTH-1:0]   r_quo;   // multiplicand, or dividend shifting into quotient
  logic [WIDTH-1:0]   r_div;   // multiplier, or divisor magnitude
  logic               r_signed;
  logic               r_neg_q;
  logic               r_neg_r;
  logic               r_dz;
  logic               r_done;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;

  logic               w_flush;
  logic               w_signed_in;
  logic               w_is_div_in;
  logic [WIDTH-1:0]   w_mag_a;
  logic [WIDTH-1:0]   w_mag_b;
  logic [2*WIDTH-1:0] w_ext_a;
  logic [2*WIDTH-1:0] w_ext_b;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_rem_nxt;
  logic [WIDTH-1:0]   w_quo_nxt;
  logic               w_early;

  // A plain flush must not discard an instruction the rest of the pipe is holding.
  assign w_flush     = exception_flush | (flush & ~stall_i);
  assign w_signed_in = is_signed_op(op_i);
  assign w_is_div_in = op_i[1];
  assign w_mag_a     = (w_signed_in & src_a_i[WIDTH-1]) ? (~src_a_i + 1'b1) : src_a_i;
  assign w_mag_b     = (w_signed_in & src_b_i[WIDTH-1]) ? (~src_b_i + 1'b1) : src_b_i;

  // Full-width product of the latched operands, sign- or zero-extended.
  assign w_ext_a = r_signed ? {{WIDTH{r_quo[WIDTH-1]}}, r_quo} : {{WIDTH{1'b0}}, r_quo};
  assign w_ext_b = r_signed ? {{WIDTH{r_div[WIDTH-1]}}, r_div} : {{WIDTH{1'b0}}, r_div};
  assign w_prod  = w_ext_a * w_ext_b;

`ifdef EXC_MULDIV_EARLY_OUT_EN
  assign w_early = (r_cnt == {CNT_W{1'b0}}) && ((r_quo < r_div) || (r_quo == {WIDTH{1'b0}}));
`else
  assign w_early = 1'b0;
`endif

  exc_div_step #(.WIDTH(WIDTH)) u_div_step (
    .i_rem     (r_rem),
    .i_quo     (r_quo),
    .i_divisor (r_div),
    .o_rem     (w_rem_nxt),
    .o_quo     (w_quo_nxt)
  );

  // Stall the front end while an accepted op is in flight; DONE lets it retire.
  assign stall_o = ((r_state == ST_IDLE) & start_i) | (r_state == ST_MUL) |
                   (r_state == ST_DIV) | (r_state == ST_FIX);
  assign done_o  = r_done;
  assign hi_o    = r_hi;
  assign lo_o    = r_lo;

  // Control FSM plus datapath registers; results are only written on entry to DONE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= ST_IDLE;
      r_cnt    <= {CNT_W{1'b0}};
      r_rem    <= {WIDTH{1'b0}};
      r_quo    <= {WIDTH{1'b0}};
      r_div    <= {WIDTH{1'b0}};
      r_signed <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_dz     <= 1'b0;
      r_done   <= 1'b0;
      r_hi     <= {WIDTH{1'b0}};
      r_lo     <= {WIDTH{1'b0}};
    end else if (w_flush) begin
      r_state <= ST_IDLE;
      r_cnt   <= {CNT_W{1'b0}};
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start_i) begin
            r_signed <= w_signed_in;
            r_neg_q  <= w_signed_in & (src_a_i[WIDTH-1] ^ src_b_i[WIDTH-1]);
            r_neg_r  <= w_signed_in & src_a_i[WIDTH-1];
            r_dz     <= (src_b_i == {WIDTH{1'b0}});
            r_quo    <= w_is_div_in ? w_mag_a : src_a_i;
            r_div    <= w_is_div_in ? w_mag_b : src_b_i;
            r_rem    <= {WIDTH{1'b0}};
            r_cnt    <= {CNT_W{1'b0}};
            r_state  <= w_is_div_in ? ST_DIV : ST_MUL;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_MUL: begin
          r_hi    <= w_prod[2*WIDTH-1:WIDTH];
          r_lo    <= w_prod[WIDTH-1:0];
          r_done  <= 1'b1;
          r_state <= ST_DONE;
        end
        ST_DIV: begin
          if (w_early) begin
            r_rem   <= r_quo;
            r_quo   <= {WIDTH{1'b0}};
            r_state <= ST_FIX;
          end else begin
            r_rem <= w_rem_nxt;
            r_quo <= w_quo_nxt;
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == CNT_LAST) begin
              r_state <= ST_FIX;
            end else begin
              r_state <= ST_DIV;
            end
          end
        end
        ST_FIX: begin
          // Remainder follows the dividend sign, which also yields HI=src_a on /0.
          r_hi    <= r_neg_r ? (~r_rem + 1'b1) : r_rem;
          r_lo    <= r_dz ? DIV_ZERO_LO[WIDTH-1:0] : (r_neg_q ? (~r_quo + 1'b1) : r_quo);
          r_done  <= 1'b1;
          r_state <= ST_DONE;
        end
        ST_DONE: begin
          if (stall_i) begin
            r_state <= ST_DONE;
          end else begin
            r_done  <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_done  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
